// File: rtl/prescaled_mode_counter.sv
// Prescaled up/down/bounce/hold counter with parallel load, programmable top limit
// and registered tick/wrap strobes. Single clock, synchronous active-low reset.
module prescaled_mode_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [PRESC_W-1:0] presc,
  input  logic [WIDTH-1:0]   limit,
  output logic [WIDTH-1:0]   cnt,
  output logic               dir,
  output logic               tick,
  output logic               wrap
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  mode_t              mode_e;
  logic [PRESC_W-1:0] pdiv;
  logic [PRESC_W-1:0] pdiv_nxt;
  logic               step;
  logic [WIDTH-1:0]   cnt_nxt;
  logic               dir_nxt;
  logic               wrap_nxt;
  logic [WIDTH-1:0]   load_clamped;

  assign mode_e       = mode_t'(mode);
  assign load_clamped = (load_val > limit) ? limit : load_val;

  always_comb begin
    step     = en && (pdiv == presc);
    pdiv_nxt = pdiv;
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    wrap_nxt = 1'b0;

    // Equality compare means a presc lowered below pdiv lets pdiv run up and wrap to 0.
    if (step)
      pdiv_nxt = '0;
    else if (en)
      pdiv_nxt = pdiv + 1'b1;

    case (mode_e)
      MODE_UP: begin
        dir_nxt = 1'b0;
        if (cnt >= limit) begin
          cnt_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      MODE_DOWN: begin
        dir_nxt = 1'b1;
        if (cnt == '0) begin
          cnt_nxt  = limit;
          wrap_nxt = 1'b1;
        end else if (cnt > limit) begin
          cnt_nxt = limit;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      MODE_BOUNCE: begin
        // A zero limit would otherwise turn around to limit-1 / 1; pin it at 0 instead.
        if (limit == '0) begin
          cnt_nxt  = '0;
          dir_nxt  = 1'b0;
          wrap_nxt = 1'b1;
        end else if (!dir) begin
          if (cnt >= limit) begin
            cnt_nxt  = limit - 1'b1;
            dir_nxt  = 1'b1;
            wrap_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          if (cnt == '0) begin
            cnt_nxt  = {{(WIDTH-1){1'b0}}, 1'b1};
            dir_nxt  = 1'b0;
            wrap_nxt = 1'b1;
          end else if (cnt > limit) begin
            cnt_nxt = limit;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      end
      MODE_HOLD: begin
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        wrap_nxt = 1'b0;
      end
      default: begin
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        wrap_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      pdiv <= '0;
      dir  <= 1'b0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      cnt  <= load_clamped;
      pdiv <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      pdiv <= pdiv_nxt;
      tick <= step;
      wrap <= step && wrap_nxt;
      if (step) begin
        cnt <= cnt_nxt;
        dir <= dir_nxt;
      end
    end
  end

endmodule

// File: tb/tb_prescaled_mode_counter.sv
// Directed bench for prescaled_mode_counter: reset, up/down/bounce/hold stepping,
// prescaling, enable gating, load clamping/priority and reset-over-load.
module tb_prescaled_mode_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] presc;
  logic [7:0] limit;
  logic [7:0] cnt;
  logic       dir;
  logic       tick;
  logic       wrap;

  int total = 0;
  int bad   = 0;

  prescaled_mode_counter #(.WIDTH(8), .PRESC_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .presc    (presc),
    .limit    (limit),
    .cnt      (cnt),
    .dir      (dir),
    .tick     (tick),
    .wrap     (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({cnt, dir, tick, wrap} !== 11'h000) begin
      bad++;
      $display("FAIL reset: cnt=%0d dir=%b tick=%b wrap=%b, want 0 0 0 0", cnt, dir, tick, wrap);
    end
  endtask

  task automatic test_up_full();
    int wraps = 0;
    do_reset();
    mode = 2'b00; presc = 4'd0; limit = 8'd255; en = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      cyc();
      total++;
      if (cnt !== 8'(k % 256) || tick !== 1'b1 || wrap !== (k == 256)) begin
        bad++;
        $display("FAIL up_full edge %0d: cnt=%0d tick=%b wrap=%b, want cnt=%0d tick=1 wrap=%b",
                 k, cnt, tick, wrap, k % 256, (k == 256));
      end
      if (wrap) wraps++;
    end
    total++;
    if (wraps != 1) begin
      bad++;
      $display("FAIL up_full wrap count: got %0d want 1", wraps);
    end
  endtask

  task automatic test_prescale();
    do_reset();
    mode = 2'b00; presc = 4'd3; limit = 8'd5; en = 1'b1;
    for (int n = 1; n <= 28; n++) begin
      cyc();
      total++;
      if (cnt !== 8'((n / 4) % 6) || tick !== (n % 4 == 0) || wrap !== (n == 24)) begin
        bad++;
        $display("FAIL prescale edge %0d: cnt=%0d tick=%b wrap=%b, want cnt=%0d tick=%b wrap=%b",
                 n, cnt, tick, wrap, (n / 4) % 6, (n % 4 == 0), (n == 24));
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] exp_cnt [8] = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2};
    logic       exp_dir [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_wrp [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    mode = 2'b10; presc = 4'd0; limit = 8'd3; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      total++;
      if (cnt !== exp_cnt[i] || dir !== exp_dir[i] || wrap !== exp_wrp[i] || tick !== 1'b1) begin
        bad++;
        $display("FAIL bounce edge %0d: cnt=%0d dir=%b wrap=%b tick=%b, want %0d %b %b 1",
                 i + 1, cnt, dir, wrap, tick, exp_cnt[i], exp_dir[i], exp_wrp[i]);
      end
    end
    // Zero limit pins the count at 0 and flags wrap on every step.
    limit = 8'd0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (cnt !== 8'd0 || dir !== 1'b0 || wrap !== 1'b1 || tick !== 1'b1) begin
        bad++;
        $display("FAIL bounce_lim0 step %0d: cnt=%0d dir=%b wrap=%b tick=%b, want 0 0 1 1",
                 i, cnt, dir, wrap, tick);
      end
    end
  endtask

  task automatic test_load();
    do_reset();
    mode = 2'b00; presc = 4'd0; limit = 8'd100;
    load = 1'b1; load_val = 8'd200;
    cyc();
    total++;
    if (cnt !== 8'd100 || tick !== 1'b0) begin
      bad++;
      $display("FAIL load_clamp: cnt=%0d tick=%b, want 100 0", cnt, tick);
    end
    en = 1'b1; load_val = 8'd7;
    cyc();
    total++;
    if (cnt !== 8'd7 || tick !== 1'b0 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL load_vs_step: cnt=%0d tick=%b wrap=%b, want 7 0 0", cnt, tick, wrap);
    end
    load = 1'b0;
    cyc();
    total++;
    if (cnt !== 8'd8 || tick !== 1'b1) begin
      bad++;
      $display("FAIL after_load: cnt=%0d tick=%b, want 8 1", cnt, tick);
    end
  endtask

  task automatic test_down_enable();
    do_reset();
    mode = 2'b01; presc = 4'd0; limit = 8'd9; en = 1'b1;
    cyc();
    total++;
    if (cnt !== 8'd9 || wrap !== 1'b1 || dir !== 1'b1) begin
      bad++;
      $display("FAIL down_wrap: cnt=%0d wrap=%b dir=%b, want 9 1 1", cnt, wrap, dir);
    end
    cyc();
    total++;
    if (cnt !== 8'd8 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL down_dec: cnt=%0d wrap=%b, want 8 0", cnt, wrap);
    end
    presc = 4'd7;
    repeat (4) cyc();  // pdiv now 4
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      total++;
      if (cnt !== 8'd8 || tick !== 1'b0) begin
        bad++;
        $display("FAIL en_frozen %0d: cnt=%0d tick=%b, want 8 0", i, cnt, tick);
      end
    end
    en = 1'b1;
    repeat (3) cyc();
    total++;
    if (cnt !== 8'd8 || tick !== 1'b0) begin
      bad++;
      $display("FAIL en_resume_early: cnt=%0d tick=%b, want 8 0", cnt, tick);
    end
    cyc();
    total++;
    if (cnt !== 8'd7 || tick !== 1'b1) begin
      bad++;
      $display("FAIL en_resume_step: cnt=%0d tick=%b, want 7 1", cnt, tick);
    end
    // Count above a lowered limit snaps to limit without wrap.
    presc = 4'd0; limit = 8'd5;
    cyc();
    total++;
    if (cnt !== 8'd5 || wrap !== 1'b0 || tick !== 1'b1) begin
      bad++;
      $display("FAIL down_clamp: cnt=%0d wrap=%b tick=%b, want 5 0 1", cnt, wrap, tick);
    end
  endtask

  task automatic test_hold();
    // Continues from cnt=5, dir=1.
    mode = 2'b11;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (cnt !== 8'd5 || dir !== 1'b1 || tick !== 1'b1 || wrap !== 1'b0) begin
        bad++;
        $display("FAIL hold %0d: cnt=%0d dir=%b tick=%b wrap=%b, want 5 1 1 0", i, cnt, dir, tick, wrap);
      end
    end
  endtask

  task automatic test_reset_over_load();
    do_reset();
    mode = 2'b01; presc = 4'd0; limit = 8'd20; en = 1'b1;
    repeat (3) cyc();  // 20, 19, 18 with dir=1
    rst_n = 1'b0; load = 1'b1; load_val = 8'd50;
    cyc();
    total++;
    if ({cnt, dir, tick, wrap} !== 11'h000) begin
      bad++;
      $display("FAIL rst_over_load: cnt=%0d dir=%b tick=%b wrap=%b, want 0 0 0 0", cnt, dir, tick, wrap);
    end
    rst_n = 1'b1; load = 1'b0; mode = 2'b00;
    cyc();
    total++;
    if (cnt !== 8'd1 || tick !== 1'b1 || dir !== 1'b0) begin
      bad++;
      $display("FAIL resume_after_rst: cnt=%0d tick=%b dir=%b, want 1 1 0", cnt, tick, dir);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; load = 1'b0;
    load_val = '0; presc = '0; limit = '0;
    test_reset();
    test_up_full();
    test_prescale();
    test_bounce();
    test_load();
    test_down_enable();
    test_hold();
    test_reset_over_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
